// File: rtl/grf.sv
// grf: 2**AW x DW general register file for the single-cycle MIPS datapath.
// It has two combinational read ports (rs -> rd1, rt -> rd2) and one synchronous
// write port fed from the result mux. Register $0 always reads as zero.
// wcnt counts committed non-$0 writes and saturates at all-ones.
// Optional build macro: GRF_BYPASS_EN adds write-through forwarding to both read ports.
// In non-synthesis builds, every committed write prints a log line.
module grf #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    a1,
  input  logic [AW-1:0]    a2,
  input  logic [AW-1:0]    a3,
  input  logic [DW-1:0]    wd,
  input  logic             we,
  input  logic [31:0]      pc,
  output logic [DW-1:0]    rd1,
  output logic [DW-1:0]    rd2,
  output logic [CNT_W-1:0] wcnt
);

  localparam int NREG = 1 << AW;

  // Power-up contents are zero even before the first reset.
  logic [DW-1:0]    regs_q [NREG] = '{default: '0};
  logic [DW-1:0]    regs_d [NREG];
  logic [CNT_W-1:0] wcnt_q = '0;
  logic [CNT_W-1:0] wcnt_d;
  logic             commit;

  // A write commits only to a non-zero target; $0 writes are dropped entirely.
  assign commit = we && (a3 != '0);

  // Next-state for storage and the saturating write counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    regs_d = regs_q;
    wcnt_d = wcnt_q;
    if (commit) begin
      regs_d[a3] = wd;
      if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
    end
  end

  // State update; reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: a whole-array clear forces the file into flops rather than a RAM macro;
      // that is accepted here because reset must visibly zero every register.
      regs_q <= '{default: '0};
      wcnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      wcnt_q <= wcnt_d;
    end
  end

  // Combinational read ports; $0 is forced to zero independent of storage.
  always_comb begin
    rd1 = (a1 == '0) ? '0 : regs_q[a1];
    rd2 = (a2 == '0) ? '0 : regs_q[a2];
`ifdef GRF_BYPASS_EN
    if (!reset && commit && (a1 == a3)) rd1 = wd;
    if (!reset && commit && (a2 == a3)) rd2 = wd;
`endif
  end

  assign wcnt = wcnt_q;

`ifndef SYNTHESIS
  // Write log for simulation: one line per committed write.
  always_ff @(posedge clk) begin
    if (!reset && commit) $display("@%08h: $%d <= %08h", pc, a3, wd);
  end
`endif

endmodule

// File: doc/grf.md
Name: grf

Overview:
- General register file for the single-cycle MIPS datapath.
- Sources the register operand that feeds the ALU operand-B mux (the rd2 path) and operand A (rd1).
- Accepts write-back data from the result mux.
- 32 x 32-bit registers, two combinational read ports, one synchronous write port.
- $0 is hardwired to zero. Includes a committed-write counter for bench cross-checking.

Parameters:
- DW, 32, data width of each register and of the read/write data ports.
- AW, 5, address width; register count is 2**AW.
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a1  input  AW  read address, port 1 (rs).
- a2  input  AW  read address, port 2 (rt).
- a3  input  AW  write address (rd/rt/$31, already selected upstream).
- wd  input  DW  write data.
- we  input  1  write enable (RegWrite).
- pc  input  32  PC of the instruction performing the write; used only for the write log.
- rd1  output  DW  read data, port 1.
- rd2  output  DW  read data, port 2.
- wcnt  output  CNT_W  number of committed non-$0 writes since reset.

Behaviour:
- Reset (synchronous, active-high): on a rising clk edge with reset=1:
  - All registers clear to 0.
  - wcnt clears to 0.
  - Any simultaneous write is discarded.
  - No log line is printed.
- Reset mid-operation therefore loses the in-flight write.
- Outputs after reset: rd1=rd2=0 for every address; wcnt=0.
- Power-up, before the first reset: registers and wcnt initialise to 0.
- Read (without GRF_BYPASS_EN):
  - rd1 = reg[a1], rd2 = reg[a2].
  - Purely combinational, zero latency.
  - Reflects register contents as of the last rising edge.
- $0: rd1/rd2 return 0 whenever the respective address is 0, regardless of storage contents.
- Write:
  - On a rising edge with reset=0, we=1, a3!=0: reg[a3] <= wd. The new value is visible on read ports after that edge.
  - we=1 with a3=0: no storage change, wcnt unchanged, no log line.
  - we=0: no change.
- Write log: each committed write prints "@<pc 8 hex>: $<a3 decimal> <= <wd 8 hex>" at the edge. Simulation only; excluded from synthesis.
- wcnt: increments by 1 per committed write and saturates at all-ones. It does not wrap.
- Simultaneous events:
  - a1==a2: both ports return the same value.
  - a1 or a2 equal to a3 while we=1: without the bypass, the read returns the old value until the edge.
  - reset and we in the same cycle: reset wins.
- All arithmetic is unsigned; no sign handling inside the block.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined: write-through forwarding.
  - If we=1, a3!=0 and a1==a3, then rd1 = wd combinationally in the same cycle.
  - Likewise for rd2 when a2==a3.
  - Forwarding is suppressed while reset=1.
  - $0 reads still return 0.
- Not defined: reads always return stored contents only, as described under Behaviour.
- Storage update, wcnt and the write log are identical in both builds.

Test Plan:
- Reset then read: assert reset 1 cycle, sweep a1/a2 over 0..31 -> rd1=rd2=0 for every address; wcnt=0.
- Basic write/read: we=1, a3=8, wd=32'h1234_5678, pc=32'h0000_3000, one edge -> afterwards a1=8 gives rd1=32'h1234_5678; wcnt=1; log "@00003000: $ 8 <= 12345678".
- $0 protection: we=1, a3=0, wd=32'hFFFF_FFFF -> a2=0 gives rd2=0; wcnt unchanged; no log line.
- Same-cycle read of the write target: reg[9]=32'h11, then we=1, a3=9, wd=32'h22, a1=9.
  - Before the edge: rd1=32'h11 without GRF_BYPASS_EN, 32'h22 with it.
  - After the edge: 32'h22 in both builds.
- Reset beats write: reg[5]=32'hA5, then reset=1, we=1, a3=5, wd=32'h5A at the same edge -> reg[5]=0; wcnt=0.
- Counter saturation: CNT_W=4, 17 committed writes -> wcnt holds 4'hF after the 15th write and stays at 4'hF.
